mem_sram_stage: RTL and testbench

MEM_SRAM_STAGE -- requirements
Module: mem_sram_stage

---
 rtl/mem_sram_stage.sv | 200 ++++++++++++++++++++
 tb/tb_mem_sram_stage.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/mem_sram_stage.sv
// mem_sram_stage
//   Memory stage adapter between a 32-bit load/store pipeline and an
//   external 16-bit asynchronous SRAM. Each 32-bit access is split into two
//   half-word accesses: low half first, then high half. The pipeline is
//   frozen through ready while an access is in flight.
//
//   Optional build macro: SRAM_WAIT_EN
//     When defined, a 3-cycle WAIT state is added after the high half.
//     Slow parts need this extra recovery time.
//
// Ports
//   clk         rising-edge clock shared with the pipeline
//   rst         asynchronous active-high reset
//   wr_en       store request (wins over rd_en when both are high)
//   rd_en       load request
//   address     32-bit byte address; the data region starts at byte 1024
//   write_data  32-bit store data
//   read_data   32-bit load result; holds until the next read completes
//   ready       1 = idle or access complete, 0 = pipeline must freeze
//   SRAM_DQ     16-bit bidirectional SRAM data bus
//   SRAM_ADDR   18-bit SRAM half-word address
//   SRAM_WE_N   SRAM write enable, active low
//
// state  | meaning
// -------+-----------------------------------------------------------
// IDLE   | no access; a request here is captured on the next edge
// ACC_LO | low half-word access at {index, 0}
// ACC_HI | high half-word access at {index, 1}
// WAIT   | recovery hold for 3 cycles (SRAM_WAIT_EN builds only)
// DONE   | access complete, ready high for one cycle

module mem_sram_stage (
    input  logic        clk,
    input  logic        rst,
    input  logic        wr_en,
    input  logic        rd_en,
    input  logic [31:0] address,
    input  logic [31:0] write_data,
    output logic [31:0] read_data,
    output logic        ready,
    inout  wire  [15:0] SRAM_DQ,
    output logic [17:0] SRAM_ADDR,
    output logic        SRAM_WE_N
);

`ifdef SRAM_WAIT_EN
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ACC_LO,
        ST_ACC_HI,
        ST_WAIT,
        ST_DONE
    } state_t;
`else
    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ACC_LO,
        ST_ACC_HI,
        ST_DONE
    } state_t;
`endif

    state_t      state_q, state_d;
    logic        is_wr_q;
    logic [16:0] idx_q;
    logic [31:0] wdata_q;
    logic [15:0] rd_lo_q;
    logic [31:0] read_data_q;

    logic        req;
    logic [16:0] idx_new;
    logic        dq_oe;
    logic [15:0] dq_out;

`ifdef SRAM_WAIT_EN
    logic [15:0] rd_hi_q;
    logic [1:0]  wait_cnt_q, wait_cnt_d;
`endif

    assign req = wr_en | rd_en;

    // ((address - 1024) >> 2) mod 2^17 equals address[18:2] - 256 mod 2^17.
    // The higher address bits and the byte offset have no effect on it.
    assign idx_new = address[18:2] - 17'd256;

    logic addr_unused;
    assign addr_unused = ^{address[31:19], address[1:0]};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        ready     = 1'b0;
        SRAM_WE_N = 1'b1;
        SRAM_ADDR = 18'd0;
        dq_oe     = 1'b0;
        dq_out    = 16'd0;
`ifdef SRAM_WAIT_EN
        wait_cnt_d = wait_cnt_q;
`endif
        case (state_q)
            ST_IDLE: begin
                ready = ~req;
                if (req) begin
                    state_d = ST_ACC_LO;
                end
            end
            ST_ACC_LO: begin
                SRAM_ADDR = {idx_q, 1'b0};
                SRAM_WE_N = ~is_wr_q;
                dq_oe     = is_wr_q;
                dq_out    = wdata_q[15:0];
                state_d   = ST_ACC_HI;
            end
            ST_ACC_HI: begin
                SRAM_ADDR = {idx_q, 1'b1};
                SRAM_WE_N = ~is_wr_q;
                dq_oe     = is_wr_q;
                dq_out    = wdata_q[31:16];
`ifdef SRAM_WAIT_EN
                // Loaded with 2 so WAIT lasts exactly 3 cycles (2, 1, 0).
                wait_cnt_d = 2'd2;
                state_d    = ST_WAIT;
`else
                state_d    = ST_DONE;
`endif
            end
`ifdef SRAM_WAIT_EN
            ST_WAIT: begin
                if (wait_cnt_q == 2'd0) begin
                    state_d = ST_DONE;
                end else begin
                    wait_cnt_d = wait_cnt_q - 2'd1;
                end
            end
`endif
            ST_DONE: begin
                ready   = 1'b1;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            is_wr_q     <= 1'b0;
            idx_q       <= 17'd0;
            wdata_q     <= 32'd0;
            rd_lo_q     <= 16'd0;
            read_data_q <= 32'd0;
        end else begin
            if (state_q == ST_IDLE && req) begin
                is_wr_q <= wr_en;
                idx_q   <= idx_new;
                wdata_q <= write_data;
            end
            if (state_q == ST_ACC_LO && !is_wr_q) begin
                rd_lo_q <= SRAM_DQ;
            end
`ifdef SRAM_WAIT_EN
            // The full word is published when WAIT ends, so read_data first
            // changes in DONE.
            if (state_q == ST_WAIT && wait_cnt_q == 2'd0 && !is_wr_q) begin
                read_data_q <= {rd_hi_q, rd_lo_q};
            end
`else
            if (state_q == ST_ACC_HI && !is_wr_q) begin
                read_data_q <= {SRAM_DQ, rd_lo_q};
            end
`endif
        end
    end

`ifdef SRAM_WAIT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_hi_q    <= 16'd0;
            wait_cnt_q <= 2'd0;
        end else begin
            wait_cnt_q <= wait_cnt_d;
            if (state_q == ST_ACC_HI && !is_wr_q) begin
                rd_hi_q <= SRAM_DQ;
            end
        end
    end
`endif

    assign read_data = read_data_q;
    assign SRAM_DQ   = dq_oe ? dq_out : 16'hzzzz;

endmodule

// File: tb/tb_mem_sram_stage.sv
module tb_mem_sram_stage;

`ifdef SRAM_WAIT_EN
    localparam int LAT = 6;
`else
    localparam int LAT = 3;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        wr_en, rd_en;
    logic [31:0] address, write_data;
    logic [31:0] read_data;
    logic        ready;
    wire  [15:0] sram_dq;
    logic [17:0] SRAM_ADDR;
    logic        SRAM_WE_N;

    logic        tb_oe, pat_en, preload;
    logic [15:0] sram [16];

    int n_tests = 0;
    int n_fail  = 0;
    int done_cnt = 0;

    typedef struct {
        logic        is_wr;
        logic [17:0] addr_lo;
        logic [31:0] wdata;
        logic [31:0] rdata;
    } exp_t;
    exp_t exp_q[$];

    always #5 clk = ~clk;

    mem_sram_stage dut (
        .clk        (clk),
        .rst        (rst),
        .wr_en      (wr_en),
        .rd_en      (rd_en),
        .address    (address),
        .write_data (write_data),
        .read_data  (read_data),
        .ready      (ready),
        .SRAM_DQ    (sram_dq),
        .SRAM_ADDR  (SRAM_ADDR),
        .SRAM_WE_N  (SRAM_WE_N)
    );

    // Shallow SRAM model: only the low 4 address bits select a cell; the full
    // address is checked separately by the monitor.
    assign sram_dq = tb_oe ? (pat_en ? 16'hA5C3 : sram[SRAM_ADDR[3:0]]) : 16'hzzzz;

    always @(posedge clk) begin
        if (preload) begin
            for (int i = 0; i < 16; i++) sram[i] <= 16'h0000;
            sram[4] <= 16'hCAFE;
            sram[5] <= 16'hF00D;
        end else if (!SRAM_WE_N) begin
            sram[SRAM_ADDR[3:0]] <= sram_dq;
        end
    end

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endfunction

    // Monitor: a completion is the first ready=1 after a run of ready=0.
    initial begin
        int          run;
        logic [17:0] a1, a2;
        logic        w1, w2;
        logic [15:0] d1, d2;
        exp_t        e;
        run = 0;
        a1 = '0; a2 = '0; w1 = 1'b1; w2 = 1'b1; d1 = '0; d2 = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                run = 0;
            end else if (!ready) begin
                if (run == 1) begin a1 = SRAM_ADDR; w1 = SRAM_WE_N; d1 = sram_dq; end
                if (run == 2) begin a2 = SRAM_ADDR; w2 = SRAM_WE_N; d2 = sram_dq; end
                run++;
            end else if (run > 0) begin
                if (exp_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_completion: got 1 access expected 0");
                end else begin
                    e = exp_q.pop_front();
                    check("latency", run, LAT);
                    check("addr_lo", {14'd0, a1}, {14'd0, e.addr_lo});
                    check("addr_hi", {14'd0, a2}, {14'd0, e.addr_lo | 18'd1});
                    check("we_n_lo", {31'd0, w1}, {31'd0, ~e.is_wr});
                    check("we_n_hi", {31'd0, w2}, {31'd0, ~e.is_wr});
                    if (e.is_wr) begin
                        check("dq_lo", {16'd0, d1}, {16'd0, e.wdata[15:0]});
                        check("dq_hi", {16'd0, d2}, {16'd0, e.wdata[31:16]});
                    end
                    check("read_data", read_data, e.rdata);
                end
                done_cnt++;
                run = 0;
            end
        end
    end

    task automatic wait_done(input int target);
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (done_cnt >= target) break;
        end
        if (done_cnt < target) begin
            n_tests++;
            n_fail++;
            $display("FAIL timeout: got %0d completions expected %0d", done_cnt, target);
        end
    endtask

    task automatic access(input logic wr, input logic rd, input logic [31:0] addr,
                          input logic [31:0] data, input logic [17:0] alo,
                          input logic [31:0] exp_rd);
        exp_t e;
        int   target;
        e.is_wr = wr; e.addr_lo = alo; e.wdata = data; e.rdata = exp_rd;
        exp_q.push_back(e);
        target = done_cnt + 1;
        @(posedge clk); #1;
        wr_en = wr; rd_en = rd; address = addr; write_data = data;
        tb_oe = rd & ~wr;
        @(posedge clk); #1;
        wr_en = 1'b0; rd_en = 1'b0;
        address = 32'hFFFF_FFFF; write_data = 32'h0BAD_0BAD;
        wait_done(target);
        tb_oe = 1'b0;
    endtask

    initial begin
        int start;
        exp_t e;
        rst = 1'b1; preload = 1'b1; tb_oe = 1'b0; pat_en = 1'b0;
        wr_en = 1'b0; rd_en = 1'b0; address = 32'd0; write_data = 32'd0;
        repeat (3) @(negedge clk);
        preload = 1'b0;
        check("rst_read_data", read_data, 32'd0);
        check("rst_we_n", {31'd0, SRAM_WE_N}, 32'd1);
        check("rst_addr", {14'd0, SRAM_ADDR}, 32'd0);
        check("rst_ready", {31'd0, ready}, 32'd1);
        @(negedge clk); rst = 1'b0;

        // Reset in the middle of a write: aborted before any SRAM write edge.
        @(posedge clk); #1;
        wr_en = 1'b1; address = 32'd1024; write_data = 32'h1111_2222;
        @(posedge clk); #1;
        wr_en = 1'b0;
        @(negedge clk);
        check("acc_lo_we_n", {31'd0, SRAM_WE_N}, 32'd0);
        rst = 1'b1;
        #2;
        check("abort_we_n", {31'd0, SRAM_WE_N}, 32'd1);
        check("abort_addr", {14'd0, SRAM_ADDR}, 32'd0);
        check("abort_read_data", read_data, 32'd0);
        tb_oe = 1'b1; pat_en = 1'b1;
        #1;
        check("abort_dq_hiz", {16'd0, sram_dq}, 32'h0000_A5C3);
        tb_oe = 1'b0; pat_en = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        check("post_rst_ready", {31'd0, ready}, 32'd1);
        check("post_rst_we_n", {31'd0, SRAM_WE_N}, 32'd1);
        check("abort_no_write", {16'd0, sram[0]}, 32'd0);

        access(1'b1, 1'b0, 32'd1024, 32'hDEAD_BEEF, 18'h00000, 32'd0);
        check("sram0", {16'd0, sram[0]}, 32'h0000_BEEF);
        check("sram1", {16'd0, sram[1]}, 32'h0000_DEAD);

        access(1'b0, 1'b1, 32'd1024, 32'd0, 18'h00000, 32'hDEAD_BEEF);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("rd_hold", read_data, 32'hDEAD_BEEF);
            check("idle_ready", {31'd0, ready}, 32'd1);
        end

        access(1'b1, 1'b1, 32'd1028, 32'h1234_5678, 18'h00002, 32'hDEAD_BEEF);
        check("sram2", {16'd0, sram[2]}, 32'h0000_5678);
        check("sram3", {16'd0, sram[3]}, 32'h0000_1234);

        access(1'b0, 1'b1, 32'd1028, 32'd0, 18'h00002, 32'h1234_5678);

        // Below 1024 wraps: byte 1020 -> word 0x1FFFF -> half-words 0x3FFFE/F.
        access(1'b1, 1'b0, 32'd1020, 32'hA5A5_5A5A, 18'h3FFFE, 32'h1234_5678);
        check("sram14", {16'd0, sram[14]}, 32'h0000_5A5A);
        check("sram15", {16'd0, sram[15]}, 32'h0000_A5A5);
        access(1'b0, 1'b1, 32'd1020, 32'd0, 18'h3FFFE, 32'hA5A5_5A5A);

        // Read held high across DONE: two back-to-back accesses.
        e.is_wr = 1'b0; e.addr_lo = 18'h00004; e.wdata = 32'd0; e.rdata = 32'hF00D_CAFE;
        exp_q.push_back(e);
        exp_q.push_back(e);
        start = done_cnt;
        @(posedge clk); #1;
        rd_en = 1'b1; address = 32'd1032; tb_oe = 1'b1;
        repeat (LAT + 2) @(posedge clk);
        #1;
        rd_en = 1'b0;
        wait_done(start + 2);
        tb_oe = 1'b0;
        repeat (4) @(negedge clk);
        check("b2b_count", done_cnt, start + 2);

        // Byte 0 -> word 0x1FF00 -> half-words 0x3FE00/1 (model cells 0/1).
        access(1'b0, 1'b1, 32'd0, 32'd0, 18'h3FE00, 32'hDEAD_BEEF);

        repeat (3) @(negedge clk);
        check("queue_empty", exp_q.size(), 0);
        check("total_done", done_cnt, 9);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish by 200000");
        $fatal(1, "watchdog");
    end

endmodule
